// File: rtl/reset_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : reset_sequencer
// Description : Ordered, acknowledged release of NUM_STAGES active-low domain
//               resets with watchdog and software re-sequence.
//               Optional macro RST_SEQ_CYCLE_COUNT_EN enables cycle_count.
// Revision    : 1.0 - initial release
//==============================================================================
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STAGE_DELAY = 16,
    parameter int ACK_TIMEOUT = 256,
    parameter int SW_HOLD     = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sw_reset_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_reset_n,
    output logic                  seq_done,
    output logic                  timeout_err,
    output logic [31:0]           cycle_count
);

    localparam int c_idx_w = (NUM_STAGES  > 1) ? $clog2(NUM_STAGES)  : 1;
    localparam int c_dly_w = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
    localparam int c_tmo_w = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int c_hld_w = (SW_HOLD     > 1) ? $clog2(SW_HOLD)     : 1;

    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_STAGES - 1);
    localparam logic [c_dly_w-1:0] c_dly_last = c_dly_w'(STAGE_DELAY - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(ACK_TIMEOUT - 1);
    localparam logic [c_hld_w-1:0] c_hld_last = c_hld_w'(SW_HOLD - 1);

    typedef enum logic [2:0] {
        ST_SYNC      = 3'd0,
        ST_DELAY     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_DONE      = 3'd3,
        ST_SW_ASSERT = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [c_idx_w-1:0]    r_idx;
    logic [c_idx_w-1:0]    w_idx_next;
    logic [c_dly_w-1:0]    r_dly;
    logic [c_dly_w-1:0]    w_dly_next;
    logic [c_tmo_w-1:0]    r_tmo;
    logic [c_tmo_w-1:0]    w_tmo_next;
    logic [c_hld_w-1:0]    r_hld;
    logic [c_hld_w-1:0]    w_hld_next;
    logic [NUM_STAGES-1:0] r_stage_rst_n;
    logic [NUM_STAGES-1:0] w_stage_rst_n_next;
    logic                  r_seq_done;
    logic                  r_timeout_err;
    logic                  w_timeout_err_next;
    logic                  w_abort;
    logic                  w_ack;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rst_sync;
    logic                   w_sync_go;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_rst_sync = r_sync[SYNC_STAGES-1];
    // Leave SYNC on the edge that raises rst_sync, so the first stage delay
    // is counted from rst_sync going high.
    assign w_sync_go  = r_sync[SYNC_STAGES-2] | w_rst_sync;
    assign w_ack      = stage_ack[r_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_SYNC;
            r_idx         <= '0;
            r_dly         <= '0;
            r_tmo         <= '0;
            r_hld         <= '0;
            r_stage_rst_n <= '0;
            r_seq_done    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_dly         <= w_dly_next;
            r_tmo         <= w_tmo_next;
            r_hld         <= w_hld_next;
            r_stage_rst_n <= w_stage_rst_n_next;
            r_seq_done    <= (w_state_next == ST_DONE);
            r_timeout_err <= w_timeout_err_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_idx_next         = r_idx;
        w_dly_next         = r_dly;
        w_tmo_next         = r_tmo;
        w_hld_next         = r_hld;
        w_stage_rst_n_next = r_stage_rst_n;
        w_timeout_err_next = r_timeout_err;
        w_abort            = 1'b0;

        case (r_state)
            ST_SYNC: begin
                if (w_sync_go) begin
                    w_state_next = ST_DELAY;
                    w_idx_next   = '0;
                    w_dly_next   = '0;
                end
            end
            ST_DELAY: begin
                if (sw_reset_req) begin
                    w_abort = 1'b1;
                end else if (r_dly == c_dly_last) begin
                    w_stage_rst_n_next[r_idx] = 1'b1;
                    w_tmo_next                = '0;
                    w_state_next              = ST_WAIT_ACK;
                end else begin
                    w_dly_next = r_dly + 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                // An ack landing on the final timeout cycle wins over the error.
                if (sw_reset_req) begin
                    w_abort = 1'b1;
                end else if (w_ack || (r_tmo == c_tmo_last)) begin
                    if (!w_ack) begin
                        w_timeout_err_next = 1'b1;
                    end
                    if (r_idx == c_last_idx) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_idx_next   = r_idx + 1'b1;
                        w_dly_next   = '0;
                        w_state_next = ST_DELAY;
                    end
                end else begin
                    w_tmo_next = r_tmo + 1'b1;
                end
            end
            ST_DONE: begin
                if (sw_reset_req) begin
                    w_abort = 1'b1;
                end
            end
            ST_SW_ASSERT: begin
                if (r_hld == c_hld_last) begin
                    w_state_next = ST_DELAY;
                    w_idx_next   = '0;
                    w_dly_next   = '0;
                end else begin
                    w_hld_next = r_hld + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_SYNC;
            end
        endcase

        if (w_abort) begin
            w_state_next       = ST_SW_ASSERT;
            w_hld_next         = '0;
            w_stage_rst_n_next = '0;
        end
    end

    assign stage_reset_n = r_stage_rst_n;
    assign seq_done      = r_seq_done;
    assign timeout_err   = r_timeout_err;

`ifdef RST_SEQ_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cycle_count <= '0;
        end else if (w_rst_sync && (r_cycle_count != 32'hFFFF_FFFF)) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign cycle_count = r_cycle_count;
`else
    assign cycle_count = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
//==============================================================================
// Module      : tb_reset_sequencer
// Description : Scoreboard bench for reset_sequencer against a timestamp model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_reset_sequencer;

    localparam int NS          = 4;
    localparam int SYNC_STAGES = 2;
    localparam int STAGE_DELAY = 16;
    localparam int ACK_TIMEOUT = 256;
    localparam int SW_HOLD     = 8;

    logic          clock;
    logic          reset;
    logic          sw_reset_req;
    logic [NS-1:0] stage_ack;
    logic [NS-1:0] stage_reset_n;
    logic          seq_done;
    logic          timeout_err;
    logic [31:0]   cycle_count;

    reset_sequencer #(
        .NUM_STAGES  (NS),
        .SYNC_STAGES (SYNC_STAGES),
        .STAGE_DELAY (STAGE_DELAY),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .SW_HOLD     (SW_HOLD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .sw_reset_req  (sw_reset_req),
        .stage_ack     (stage_ack),
        .stage_reset_n (stage_reset_n),
        .seq_done      (seq_done),
        .timeout_err   (timeout_err),
        .cycle_count   (cycle_count)
    );

    initial begin
        clock = 1'b1;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic [NS-1:0] rst_n;
        logic          done;
        logic          err;
        logic [31:0]   cnt;
    } exp_t;

    exp_t q[$];

    int n_chk  = 0;
    int n_fail = 0;

    // e is the index of the next rising clock edge
    longint e = 0;
    longint last_rise = 0;
    longint t_rise0 = -1;
    longint t_done  = -1;
    int     rlow = 0;

    // Model state expressed as released-stage count plus event timestamps
    bit     m_in_rst;
    int     m_rel;
    bit     m_done;
    bit     m_err;
    bit     m_wait;
    longint m_k0;
    longint m_rel_at;
    longint m_wait_since;
    longint m_hold_end;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s near edge %0d: got %0h, expected %0h", name, e - 1, act, exp_v);
        end
    endtask

    task automatic model_clear();
        m_in_rst     = 1'b1;
        m_rel        = 0;
        m_done       = 1'b0;
        m_err        = 1'b0;
        m_wait       = 1'b0;
        m_k0         = 64'sh7FFF_FFFF_FFFF;
        m_rel_at     = -1;
        m_wait_since = -1;
        m_hold_end   = -1;
    endtask

    function automatic exp_t model_out();
        exp_t x;
        x.rst_n = NS'((1 << m_rel) - 1);
        x.done  = m_done;
        x.err   = m_err;
`ifdef RST_SEQ_CYCLE_COUNT_EN
        if (!m_in_rst && e >= m_k0)
            x.cnt = ((e - m_k0) > 64'sh0_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(e - m_k0);
        else
            x.cnt = 32'h0;
`else
        x.cnt = 32'h0;
`endif
        return x;
    endfunction

    task automatic model_edge(input logic sw, input logic [NS-1:0] ack);
        if (e <= m_k0) return;
        if (sw && e > m_hold_end) begin
            m_rel      = 0;
            m_done     = 1'b0;
            m_wait     = 1'b0;
            m_hold_end = e + SW_HOLD;
            m_rel_at   = e + SW_HOLD + STAGE_DELAY;
            return;
        end
        if (e == m_rel_at) begin
            m_rel++;
            m_wait       = 1'b1;
            m_wait_since = e;
            m_rel_at     = -1;
            return;
        end
        if (m_wait && (ack[m_rel-1] || e == m_wait_since + ACK_TIMEOUT)) begin
            if (!ack[m_rel-1]) m_err = 1'b1;
            m_wait = 1'b0;
            if (m_rel == NS) m_done = 1'b1;
            else             m_rel_at = e + STAGE_DELAY;
        end
    endtask

    task automatic step(input logic rst_v, input logic sw_v, input logic [NS-1:0] ack_v);
        @(negedge clock);
        if (!rst_v && reset) begin
            model_clear();
            q.push_back(model_out());
        end
        if (rst_v && !reset) begin
            m_in_rst  = 1'b0;
            m_k0      = e + SYNC_STAGES - 1;
            m_rel_at  = m_k0 + STAGE_DELAY;
            last_rise = e;
        end
        reset        = rst_v;
        sw_reset_req = sw_v;
        stage_ack    = ack_v;
        if (!rst_v) model_clear();
        else        model_edge(sw_v, ack_v);
        q.push_back(model_out());
        e++;
    endtask

    // Monitor: every clock edge or asynchronous reset assertion presents a
    // new output snapshot to compare against the next queued expectation.
    initial begin
        exp_t x;
        logic prev0;
        logic prevd;
        prev0 = 1'b0;
        prevd = 1'b0;
        #1;
        forever begin
            @(posedge clock or negedge reset);
            #1;
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_underflow near edge %0d: got no expectation, expected one queued", e - 1);
            end else begin
                x = q.pop_front();
                chk("stage_reset_n", 32'(stage_reset_n), 32'(x.rst_n));
                chk("seq_done",      32'(seq_done),      32'(x.done));
                chk("timeout_err",   32'(timeout_err),   32'(x.err));
                chk("cycle_count",   cycle_count,        x.cnt);
            end
            if (stage_reset_n[0] && !prev0) t_rise0 = e - 1;
            if (seq_done && !prevd)         t_done  = e - 1;
            prev0 = stage_reset_n[0];
            prevd = seq_done;
        end
    end

    initial begin
        logic          race;
        logic [NS-1:0] a;
        reset        = 1'b0;
        sw_reset_req = 1'b0;
        stage_ack    = '0;
        model_clear();

        // Power-on with every ack tied high
        repeat (5) step(1'b0, 1'b0, '1);
        repeat (90) step(1'b1, 1'b0, '1);
        chk("pwr_stage0_latency", 32'(t_rise0 - last_rise), 32'(SYNC_STAGES + STAGE_DELAY - 1));
        chk("pwr_done_latency", 32'(t_done - last_rise),
            32'(SYNC_STAGES + STAGE_DELAY - 1 + (STAGE_DELAY + 1) * (NS - 1) + 1));

        // Software re-sequence from DONE
        step(1'b1, 1'b1, '1);
        repeat (100) step(1'b1, 1'b0, '1);

        // Missing ack on stage 1 -> watchdog fires, sequence still completes
        step(1'b1, 1'b1, '1);
        a = '1;
        a[1] = 1'b0;
        repeat (400) step(1'b1, 1'b0, a);

        // Re-sequence keeps the sticky error
        step(1'b1, 1'b1, '1);
        repeat (100) step(1'b1, 1'b0, '1);

        // Ack arriving on the very last timeout cycle of stage 0
        repeat (3) step(1'b0, 1'b0, '1);
        race = 1'b0;
        for (int i = 0; i < 400; i++) begin
            a = '1;
            if (!race) begin
                a[0] = 1'b0;
                if (m_wait && m_rel == 1 && e == m_wait_since + ACK_TIMEOUT) begin
                    a[0] = 1'b1;
                    race = 1'b1;
                end
            end
            step(1'b1, 1'b0, a);
        end
        chk("race_no_timeout_err", 32'(timeout_err), 32'd0);

        // Primary reset while waiting on stage 2's ack
        step(1'b1, 1'b1, '1);
        a = '1;
        a[2] = 1'b0;
        for (int i = 0; i < 300 && !(m_rel == 3 && m_wait); i++) step(1'b1, 1'b0, a);
        repeat (5) step(1'b1, 1'b0, a);
        repeat (4) step(1'b0, 1'b0, '1);
        repeat (90) step(1'b1, 1'b0, '1);

        // Randomised acks, software requests and primary resets
        for (int b = 0; b < 8; b++) begin
            logic [NS-1:0] en;
            en = NS'($urandom);
            for (int i = 0; i < 250; i++) begin
                logic r;
                logic s;
                for (int k = 0; k < NS; k++) a[k] = en[k] & ($urandom_range(0, 3) == 0);
                s = ($urandom_range(0, 79) == 0);
                if (rlow > 0) begin
                    r = 1'b0;
                    rlow--;
                end else if ($urandom_range(0, 299) == 0) begin
                    r = 1'b0;
                    rlow = $urandom_range(0, 2);
                end else begin
                    r = 1'b1;
                end
                step(r, s, a);
            end
        end

        @(posedge clock);
        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sits directly downstream of the clock and active-low reset generator. Consumes its `clock` and `reset` and produces ordered, synchronously-released active-low resets for NUM_STAGES DUT domains.
- Each stage is released only after a programmable delay and after the previous stage acknowledges, with a watchdog that flags a missing acknowledge.
- A software reset request re-runs the whole sequence without asserting the primary reset.

Parameters:
- NUM_STAGES, 4: number of sequenced reset outputs; 1..16.
- SYNC_STAGES, 2: deassertion synchronizer depth in flops; at least 2.
- STAGE_DELAY, 16: clock cycles between entering a stage and releasing its reset; at least 1.
- ACK_TIMEOUT, 256: cycles to wait for a stage acknowledge before flagging an error; at least 1.
- SW_HOLD, 8: cycles all outputs stay asserted after a software reset request; at least 1.

Ports:
- `clock`  input  1  sole clock.
- `reset`  input  1  asynchronous, active-low primary reset.
- `sw_reset_req`  input  1  single-cycle request to re-run the sequence.
- `stage_ack`  input  NUM_STAGES  bit k high means domain k is out of reset and ready; level, sampled each clock.
- `stage_reset_n`  output  NUM_STAGES  active-low reset per domain.
- `seq_done`  output  1  high when all stages are released.
- `timeout_err`  output  1  sticky acknowledge-timeout flag.
- `cycle_count`  output  32  cycles since synchronized reset release; saturates at 0xFFFF_FFFF.

Behaviour:
- Reset is asynchronous and active-low. Assertion of `reset` immediately and asynchronously drives:
  - `stage_reset_n` = all zeros, `seq_done` = 0, `timeout_err` = 0, `cycle_count` = 0.
  - State = SYNC, stage index = 0, counters = 0.
- Deassertion passes through a SYNC_STAGES-deep synchronizer; `rst_sync` goes high SYNC_STAGES rising edges after `reset` rises.
- State machine, advancing on rising `clock`:
  - SYNC: wait for `rst_sync` = 1, then go to DELAY with delay counter = 0.
  - DELAY: increment the delay counter. When it reaches STAGE_DELAY-1, set `stage_reset_n[idx]` = 1 on that edge and go to WAIT_ACK with timeout counter = 0.
  - WAIT_ACK, when `stage_ack[idx]` = 1:
    - If idx = NUM_STAGES-1, go to DONE.
    - Otherwise increment idx and go to DELAY.
  - WAIT_ACK, timeout path: the timeout counter increments each cycle without an ack. When it reaches ACK_TIMEOUT-1 without an ack, set `timeout_err` = 1 and advance exactly as if acked. The sequence never stalls.
  - DONE: `seq_done` = 1 (registered, visible the cycle after entry). Hold until `sw_reset_req` or `reset`.
  - SW_ASSERT: all `stage_reset_n` = 0, `seq_done` = 0. Hold SW_HOLD cycles, then go to DELAY with idx = 0.
- Latency from `rst_sync` high to `stage_reset_n[0]` high is STAGE_DELAY cycles.
- Stage k+1 is released STAGE_DELAY cycles after the cycle in which `stage_ack[k]` is sampled high.
- Released stages stay released. Outputs are monotonic within one sequence: bit k is never released before bit k-1.
- `sw_reset_req` may arrive in any state other than SYNC. It goes to SW_ASSERT on the next edge and aborts any in-progress sequence. It is ignored in SYNC and while already in SW_ASSERT.
- `timeout_err` is sticky. Only primary `reset` clears it; `sw_reset_req` does not.
- An ack already high on entry to WAIT_ACK is accepted in the first WAIT_ACK cycle. Ack and timeout in the same cycle count as an ack: no error.
- `stage_ack` bits other than the current idx are ignored.
- Primary `reset` asserted mid-sequence or in SW_ASSERT returns everything to reset values immediately.
- `cycle_count` behaviour:
  - Starts counting on the first cycle `rst_sync` = 1 and increments every cycle after that.
  - Saturates at all-ones with no wrap.
  - Not cleared by `sw_reset_req`.
- All `stage_reset_n` bits are driven directly from flops; no combinational glitch path.

Optional Feature:
RST_SEQ_CYCLE_COUNT_EN:
- Defined: `cycle_count` behaves as specified above.
- Undefined: the counter logic is removed and `cycle_count` is tied to 32'h0.
- All other behaviour is identical in both builds.

Test Plan:
1. Power-on: `reset` low 5 cycles then high; all `stage_ack` tied high; defaults (NUM_STAGES=4, SYNC_STAGES=2, STAGE_DELAY=16) -> `stage_reset_n[0]` rises 2+16=18 edges after `reset` rises. Each later stage rises 17 cycles after the previous (16-cycle delay plus 1 ack cycle). `seq_done`=1 after stage 3; `timeout_err`=0.
2. Missing ack: `stage_ack[1]` held 0, others 1 -> after stage 1 is released, `timeout_err` rises 256 cycles later, stage 2 is still released, and `seq_done` eventually = 1.
3. Software re-sequence: in DONE, pulse `sw_reset_req` 1 cycle -> all `stage_reset_n`=0 for 8 cycles, then the full sequence repeats. `timeout_err` is unchanged from its prior value; `cycle_count` keeps incrementing.
4. Mid-sequence abort: assert `reset` low asynchronously while in WAIT_ACK for stage 2 -> outputs drop to all-zero immediately without a clock edge. On release, the sequence restarts from stage 0.
5. Ack/timeout race: `stage_ack[0]` rises exactly on timeout cycle 255 -> no `timeout_err`; sequence advances to stage 1.
6. Counter build check: with RST_SEQ_CYCLE_COUNT_EN defined, `cycle_count` = 100 exactly 100 edges after `rst_sync` rises. Without it, `cycle_count` reads 0 throughout.
